instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Program-counter and fetch-control stage of the primitive programmable device. It sits directly upstream of the 32x8 instruction ROM and drives its 8-bit address. It takes back the combinational 32-bit read data and computes the next PC: sequential, unconditional jump, or conditional branch on the ALU flag. It presents the current instruction to decode with a valid qualifier and supports stall, halt/resume and out-of-range fault handling.

Parameters:
ADDR_W, 8, PC/ROM address width; PC arithmetic is modulo 2^ADDR_W.
MEM_DEPTH, 32, number of implemented ROM words; any PC >= MEM_DEPTH is a fault.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en_i  in  1  run enable; low holds the PC and parks the FSM in IDLE.
stall_i  in  1  downstream stall; holds the PC, and instr_valid_o goes low.
halt_req_i  in  1  request to halt after the current cycle.
resume_i  in  1  leave HALT.
flag_i  in  1  ALU comparison result for conditional branches, same cycle.
instr_i  in  32  ROM read data for addr_o, combinational.
addr_o  out  ADDR_W  ROM address; always equals pc_o.
pc_o  out  ADDR_W  current PC.
instr_o  out  32  instr_i passed through to decode.
instr_valid_o  out  1  instruction is executed and retired this cycle.
halted_o  out  1  high in HALT or FAULT.
fault_o  out  1  high in FAULT only.
wrap_o  out  1  one-cycle pulse when the PC update overflows or underflows modulo 2^ADDR_W.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, state=IDLE. instr_valid_o=0, halted_o=0, fault_o=0, wrap_o=0.
- Instruction fields:
  - B = instr[31]: unconditional jump.
  - C = instr[30]: conditional branch.
  - OFF = instr[7:0], signed, sign-extended to ADDR_W.
- Next PC:
  - If B: PC + OFF.
  - Else if C and flag_i: PC + OFF.
  - Else: PC + 1.
  - B has priority over C. Addition is modulo 2^ADDR_W.
  - wrap_o = carry/borrow out of the ADDR_W-bit add, asserted only on the cycle the PC updates.
- States: IDLE, RUN, HALT, FAULT.
  - IDLE: en_i=1 -> RUN. PC held.
  - RUN, priority order:
    1. en_i=0 -> IDLE.
    2. halt_req_i=1 -> HALT; no retire that cycle.
    3. stall_i=1 -> stay in RUN, PC held.
    4. Otherwise retire: PC <= next PC. If next PC >= MEM_DEPTH -> FAULT and the PC keeps the offending value.
  - HALT: resume_i=1 -> RUN (retire resumes the following cycle). en_i=0 -> IDLE. halt_req_i is ignored.
  - FAULT: sticky; exit only by reset.
- instr_valid_o = (state==RUN) & en_i & ~halt_req_i & ~stall_i. The PC updates exactly when instr_valid_o=1, on the next clock edge.
- Latency: the ROM is combinational, so an instruction is fetched, decoded and retired in one cycle. The new PC is visible on addr_o one cycle after the retiring edge.
- A jump with OFF=0 is a legal self-loop; the PC is unchanged and instr_valid_o stays high every cycle.
- Reset mid-operation aborts immediately; no partial PC update.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output port retired_cnt_o [15:0].
  - Increments on each instr_valid_o=1 cycle and saturates at 16'hFFFF.
  - Cleared on reset only.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE/RUN/HALT/FAULT).
  - Field constants B_BIT=31, C_BIT=30, OFF_MSB=7, OFF_LSB=0.
  - Default ADDR_W and MEM_DEPTH.
- One combinational sub-module, pc_next_logic:
  - Inputs: pc, instr, flag.
  - Outputs: next_pc, wrap, out_of_range.
- The FSM and PC register live in instr_fetch_unit.

Test Plan:
- Reset, en_i=1, ROM filled with non-branch words -> addr_o steps 0,1,2,...; instr_valid_o=1 every cycle.
- PC=5, instr = B=1, OFF=8'hFD -> next addr_o=2. PC=3, instr = C=1, OFF=4: flag_i=1 -> 7; flag_i=0 -> 4.
- stall_i high for 3 cycles at PC=10 -> addr_o holds 10 and instr_valid_o=0 for those 3 cycles. halt_req_i at PC=12 -> HALT, halted_o=1, PC stays 12. resume_i -> PC advances to 13 on the next retire.
- PC=31, non-branch -> next PC 32 >= MEM_DEPTH -> FAULT: fault_o=1, halted_o=1, PC=32. Resume is ignored until rst_n pulse, after which PC=0 and state is IDLE.
- PC=2, B=1, OFF=8'hF0 -> PC=242 with wrap_o pulse, then FAULT. With MEM_DEPTH=256, PC=255 and +1 -> 0 with wrap_o=1 and no fault.
- With FETCH_PERF_CNT_EN: 10 retires, 2 stalls, 1 halt cycle -> retired_cnt_o=10. rst_n asserted mid-run -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch unit: FSM state encoding,
//   instruction field positions and default geometry.
//   Optional build macro used by the fetch unit: FETCH_PERF_CNT_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   // Instruction word layout.
   localparam int INSTR_W = 32;
   localparam int B_BIT   = 31;   // unconditional jump
   localparam int C_BIT   = 30;   // conditional branch on ALU flag
   localparam int OFF_MSB = 7;    // signed PC-relative offset
   localparam int OFF_LSB = 0;
   localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_MEM_DEPTH = 32;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Fetch bus between the fetch unit, the instruction ROM and decode.
//   Signals:
//     addr_o        ROM address (always the current PC)
//     instr_i       combinational ROM read data for addr_o
//     pc_o          current PC, for decode/debug
//     instr_o       instruction forwarded to decode
//     instr_valid_o instruction is executed and retired this cycle
//   Handshake: instr_valid_o is a pure valid with no ready. Backpressure comes
//   from stall_i on the fetch unit: while stall_i is high instr_valid_o is low
//   and the PC holds, so decode sees an instruction exactly once, in the cycle
//   it retires.
//   Modports: master = fetch unit, slave = ROM/decode side.
interface instr_fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic [ADDR_W-1:0]  addr_o;
   logic [INSTR_W-1:0] instr_i;
   logic [ADDR_W-1:0]  pc_o;
   logic [INSTR_W-1:0] instr_o;
   logic               instr_valid_o;

   modport master (
      output addr_o,
      output pc_o,
      output instr_o,
      output instr_valid_o,
      input  instr_i
   );

   modport slave (
      input  addr_o,
      input  pc_o,
      input  instr_o,
      input  instr_valid_o,
      output instr_i
   );

endinterface

// File: rtl/pc_next_logic.sv
// pc_next_logic
//   Combinational next-PC computation.
//   Ports:
//     pc           current PC
//     instr        instruction at pc
//     flag         ALU comparison result for conditional branches
//     next_pc      PC + OFF when jumping/branching taken, else PC + 1 (mod 2^ADDR_W)
//     wrap         carry or borrow out of the ADDR_W-bit add
//     out_of_range next_pc >= MEM_DEPTH
//   Assumes ADDR_W >= OFF_W so the offset sign-extends into the PC width.
module pc_next_logic
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               flag,
   output logic [ADDR_W-1:0]  next_pc,
   output logic               wrap,
   output logic               out_of_range
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

   logic              taken;
   logic [OFF_W-1:0]  off;
   logic [ADDR_W:0]   step;
   logic [ADDR_W:0]   sum;
   logic              unused_instr_bits;

   assign unused_instr_bits = ^instr[C_BIT-1:OFF_MSB+1];

   always_comb begin
      // B has priority, but either taken path uses the same offset.
      taken = instr[B_BIT] | (instr[C_BIT] & flag);
      off   = instr[OFF_MSB:OFF_LSB];
      // One extra bit of width: for a positive step bit ADDR_W is the carry;
      // for a negative (sign-extended) step it is set exactly when the
      // result went below zero, i.e. the borrow.
      step  = taken ? {{(ADDR_W + 1 - OFF_W){off[OFF_W-1]}}, off}
                    : (ADDR_W + 1)'(1);
      sum   = {1'b0, pc} + step;
      next_pc      = sum[ADDR_W-1:0];
      wrap         = sum[ADDR_W];
      out_of_range = ({1'b0, next_pc} >= DEPTH_LIM);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   PC register and fetch-control FSM (IDLE/RUN/HALT/FAULT) in front of a
//   combinational instruction ROM.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     en_i           run enable; low parks the FSM in IDLE
//     stall_i        downstream stall; holds the PC
//     halt_req_i     enter HALT instead of retiring this cycle
//     resume_i       leave HALT
//     flag_i         ALU flag for conditional branches
//     bus            fetch bus (master): addr_o, instr_i, pc_o, instr_o, instr_valid_o
//     halted_o       high in HALT or FAULT
//     fault_o        high in FAULT (sticky until reset)
//     wrap_o         one-cycle pulse, in the cycle after a retire whose PC add wrapped
//     state_o        FSM state for debug/observation
//     retired_cnt_o  saturating retire counter (only with FETCH_PERF_CNT_EN)
//   Build macro: FETCH_PERF_CNT_EN adds retired_cnt_o.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int RESET_PC  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                stall_i,
   input  logic                halt_req_i,
   input  logic                resume_i,
   input  logic                flag_i,
   instr_fetch_unit_if.master  bus,
   output logic                halted_o,
   output logic                fault_o,
   output logic                wrap_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]         retired_cnt_o,
`endif
   output fetch_state_t        state_o
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic              wrap_q;
   logic [ADDR_W-1:0] next_pc;
   logic              next_wrap;
   logic              next_oor;
   logic              retire;

   pc_next_logic #(
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_pc_next (
      .pc           (pc),
      .instr        (bus.instr_i),
      .flag         (flag_i),
      .next_pc      (next_pc),
      .wrap         (next_wrap),
      .out_of_range (next_oor)
   );

   // Retire is combinational on the same-cycle controls because the ROM
   // answers in the same cycle; it is also the PC load enable.
   assign retire = (state == ST_RUN) & en_i & ~halt_req_i & ~stall_i;

   assign bus.addr_o        = pc;
   assign bus.pc_o          = pc;
   assign bus.instr_o       = bus.instr_i;
   assign bus.instr_valid_o = retire;

   assign halted_o = (state == ST_HALT) | (state == ST_FAULT);
   assign fault_o  = (state == ST_FAULT);
   assign wrap_o   = wrap_q;
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         pc     <= ADDR_W'(RESET_PC);
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en_i) state <= ST_RUN;
            end
            ST_RUN: begin
               if (!en_i) begin
                  state <= ST_IDLE;
               end else if (halt_req_i) begin
                  state <= ST_HALT;
               end else if (!stall_i) begin
                  // The offending PC is kept on fault so it can be inspected.
                  pc     <= next_pc;
                  wrap_q <= next_wrap;
                  if (next_oor) state <= ST_FAULT;
               end
            end
            ST_HALT: begin
               if (resume_i)   state <= ST_RUN;
               else if (!en_i) state <= ST_IDLE;
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] retired_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 16'h0000;
      end else if (retire && (retired_cnt != 16'hFFFF)) begin
         retired_cnt <= retired_cnt + 16'h0001;
      end
   end

   assign retired_cnt_o = retired_cnt;
`endif

endmodule
